paralelo_serial_tx: RTL and testbench

PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

---
 rtl/paralelo_serial_tx_pkg.sv | 19 +
 rtl/paralelo_serial_tx_piso_shift8.sv | 30 +++
 rtl/paralelo_serial_tx.sv | 93 +++++++++
 tb/tb_paralelo_serial_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/paralelo_serial_tx_pkg.sv
// Physical-layer constants shared by the parallel-to-serial transmitter.
// Word-count feature in the transmitter is enabled with TX_WORD_COUNT_EN.
package paralelo_serial_tx_pkg;

  localparam int          WORD_W         = 8;
  localparam int          BIT_CNT_W      = 3;
  localparam int          SYNC_CNT_W     = 3;
  localparam int          WORD_CNT_W     = 16;
  localparam logic [7:0]  COM_DEF        = 8'hBC;
  localparam logic [7:0]  IDLE_DEF       = 8'h7C;
  localparam int          SYNC_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx_piso_shift8.sv
// 8-bit load/shift register, MSB first; i_load presents the new MSB on the next edge.
module piso_shift8
  import paralelo_serial_tx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_bit
);

  logic [WORD_W-1:0] r_shift;
  logic              r_bit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_bit   <= 1'b0;
    end else if (i_load) begin
      r_shift <= {i_word[WORD_W-2:0], 1'b0};
      r_bit   <= i_word[WORD_W-1];
    end else begin
      r_shift <= {r_shift[WORD_W-2:0], 1'b0};
      r_bit   <= r_shift[WORD_W-1];
    end
  end

  assign o_bit = r_bit;

endmodule

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: COM preamble, then data/IDLE words, MSB first.
// Optional 16-bit valid-word counter on word_cnt when TX_WORD_COUNT_EN is defined.
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  parameter logic [7:0] COM        = COM_DEF,
  parameter logic [7:0] IDLE       = IDLE_DEF,
  parameter int         SYNC_WORDS = SYNC_WORDS_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              load,
  output logic              active
`ifdef TX_WORD_COUNT_EN
  ,
  output logic [WORD_CNT_W-1:0] word_cnt
`endif
);

  localparam int unsigned LP_LAST_SYNC = SYNC_WORDS - 1;

  tx_state_e             r_state;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [SYNC_CNT_W-1:0] r_sync_cnt;
  logic                  r_load;
  logic                  r_active;
  logic                  w_boundary;
  logic                  w_to_data;
  logic                  w_data_word;
  logic [WORD_W-1:0]     w_word;

  assign w_boundary  = (r_bit_cnt == '0);
  // The boundary that closes the last COM word already carries the first data word.
  assign w_to_data   = (r_state == ST_SYNC) && (32'(r_sync_cnt) >= LP_LAST_SYNC);
  assign w_data_word = (r_state == ST_DATA) || w_to_data;
  assign w_word      = !w_data_word ? COM : (valid_in ? data_in : IDLE);

`ifdef TX_WORD_COUNT_EN
  logic [WORD_CNT_W-1:0] r_word_cnt;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_word_cnt <= '0;
    end else if (w_boundary && w_data_word && valid_in) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RST;
      r_bit_cnt  <= '0;
      r_sync_cnt <= '0;
      r_load     <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      r_load    <= w_boundary;
      if (w_boundary) begin
        case (r_state)
          ST_RST: r_state <= ST_SYNC;
          ST_SYNC: begin
            r_sync_cnt <= r_sync_cnt + 1'b1;
            if (w_to_data) begin
              r_state  <= ST_DATA;
              r_active <= 1'b1;
            end
          end
          ST_DATA: r_state <= ST_DATA;
          default: r_state <= ST_RST;
        endcase
      end
    end
  end

  piso_shift8 u_piso (
    .i_clk   (clk_32f),
    .i_rst_n (reset),
    .i_load  (w_boundary),
    .i_word  (w_word),
    .o_bit   (data_out)
  );

  assign load   = r_load;
  assign active = r_active;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: stimulus pushes expected words, a monitor
// reassembles the serial stream at each load pulse and compares.
module tb_paralelo_serial_tx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int         SW   = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out;
  logic       load;
  logic       active;
`ifdef TX_WORD_COUNT_EN
  logic [15:0] word_cnt;
`endif

  paralelo_serial_tx #(.COM(COM), .IDLE(IDLE), .SYNC_WORDS(SW)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .load     (load),
    .active   (active)
`ifdef TX_WORD_COUNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] word;
    logic       act;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   word_idx = 0;
  int   pushed   = 0;
  int   aborted  = 0;
  int   checked_words = 0;
  int   exp_wcnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: word n after reset release is COM for n < SW, else data_in or IDLE.
  task automatic push_expected(input logic v, input logic [7:0] d);
    exp_t e;
    e.act  = (word_idx >= SW);
    e.word = (word_idx < SW) ? COM : (v ? d : IDLE);
    if (word_idx >= SW && v) exp_wcnt = (exp_wcnt + 1) % 65536;
    q.push_back(e);
    pushed++;
    word_idx++;
    $display("push word %0d: data_in=%h valid=%0b -> expect %h active=%0b",
             word_idx - 1, d, v, e.word, e.act);
  endtask

  // Entered and left at a negedge just before a word boundary.
  task automatic send_word(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    push_expected(v, d);
    @(posedge clk_32f);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_32f);
      data_in  = 8'($urandom);
      valid_in = 1'($urandom);
      if (i == 3) data_in = 8'h00;
      @(posedge clk_32f);
    end
    @(negedge clk_32f);
  endtask

  task automatic abort_word(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    push_expected(v, d);
    @(posedge clk_32f);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk_32f);
      data_in = 8'($urandom);
      @(posedge clk_32f);
    end
    @(negedge clk_32f);
    #1 reset = 1'b0;
    aborted++;
    #1;
    chk("abort_data_out", 16'(data_out), 16'd0);
    chk("abort_load", 16'(load), 16'd0);
    chk("abort_active", 16'(active), 16'd0);
    exp_wcnt = 0;
    word_idx = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data_out"}, 16'(data_out), 16'd0);
    chk({tag, "_load"}, 16'(load), 16'd0);
    chk({tag, "_active"}, 16'(active), 16'd0);
`ifdef TX_WORD_COUNT_EN
    chk({tag, "_word_cnt"}, word_cnt, 16'd0);
`endif
  endtask

  // Monitor: collects 8 bits from each load pulse and compares against the queue head.
  logic       collecting = 1'b0;
  int         nbits = 0;
  logic [7:0] sh;
  exp_t       cur;

  always @(negedge clk_32f) begin
    if (!reset) begin
      collecting = 1'b0;
      nbits = 0;
    end else if (load) begin
      if (collecting && nbits != 8) chk("load_spacing", 16'(nbits), 16'd8);
      if (q.size() == 0) begin
        chk("unexpected_load", 16'(q.size()), 16'd1);
        collecting = 1'b0;
      end else begin
        cur = q.pop_front();
        collecting = 1'b1;
        sh = {7'b0, data_out};
        nbits = 1;
        chk("active", 16'(active), 16'(cur.act));
      end
    end else if (collecting) begin
      if (nbits == 8) begin
        chk("load_missing", 16'(load), 16'd1);
        collecting = 1'b0;
      end else begin
        sh = {sh[6:0], data_out};
        nbits++;
        chk("active", 16'(active), 16'(cur.act));
        if (nbits == 8) begin
          checked_words++;
          $display("word out: %h expected %h active=%0b", sh, cur.word, active);
          chk("serial_word", 16'(sh), 16'(cur.word));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #50;
    check_reset_state("reset");
    repeat (10) @(negedge clk_32f);
    reset = 1'b1;

    for (int i = 0; i < SW; i++) send_word(1'($urandom), 8'($urandom));
    send_word(1'b1, 8'hFF);
    send_word(1'b1, 8'hEE);
    send_word(1'b0, 8'h77);
    send_word(1'b1, 8'hDD);
    send_word(1'b1, 8'h00);
    send_word(1'b1, 8'hBC);
    send_word(1'b1, 8'h7C);
    for (int i = 0; i < 16; i++) send_word(1'($urandom), 8'($urandom));
`ifdef TX_WORD_COUNT_EN
    #1 chk("word_cnt_mid", word_cnt, 16'(exp_wcnt));
`endif

    abort_word(1'b1, 8'hA5);
    repeat (3) @(negedge clk_32f);
    #1 check_reset_state("reset2");
    @(negedge clk_32f);
    reset = 1'b1;

    for (int i = 0; i < SW; i++) send_word(1'($urandom), 8'($urandom));
    send_word(1'b1, 8'h12);
    send_word(1'b0, 8'h34);
    send_word(1'b1, 8'h56);
    send_word(1'b0, 8'h78);
    send_word(1'b1, 8'h9A);

    #1;
`ifdef TX_WORD_COUNT_EN
    chk("word_cnt_final", word_cnt, 16'(exp_wcnt));
`endif
    chk("queue_empty", 16'(q.size()), 16'd0);
    chk("words_checked", 16'(checked_words), 16'(pushed - aborted));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
